// File: rtl/toggle_link_pkg.sv
// Shared types and parameter helpers for the toggle-encoded event link.
// Used by the transmitter top and its saturating pending counter.
package toggle_link_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tx_state_e;

    localparam int GAP_MIN = 1;

    // Largest value an unsigned counter of the given width can hold.
    function automatic int pend_max(input int cnt_w);
        return (32'sd1 <<< cnt_w) - 32'sd1;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter: counts up on inc, down on dec, holds at 0 and at max.
// ovf_stb flags an increment lost at saturation; cnt_nxt exposes the value being loaded.
module sat_updown_cnt
    import toggle_link_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         ovf_stb
);

    localparam logic [W-1:0] MAX_V = W'(pend_max(W));

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;
    logic         ovf_stb_s;

    // Next-count decode; inc and dec together cancel, so saturation never drops that event.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_stb_s = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r == MAX_V) begin
                    ovf_stb_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + W'(1);
                end
            end
            2'b01: begin
                if (cnt_r != {W{1'b0}}) begin
                    cnt_nxt_s = cnt_r - W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign cnt_nxt = cnt_nxt_s;
    assign ovf_stb = ovf_stb_s;

endmodule

// File: rtl/toggle_event_tx.sv
// Toggle-encoded event transmitter: each queued event flips `out` once, with flips
// spaced at least GAP cycles apart so an XOR edge-detecting receiver never merges them.
module toggle_event_tx
    import toggle_link_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_in,
    input  logic             ovf_clr,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             ovf
);

    localparam int PEND_MAX = pend_max(CNT_W);

    if (GAP < GAP_MIN || GAP > PEND_MAX) begin : g_gap_check
        $error("toggle_event_tx: GAP must lie in 1..2^CNT_W-1");
    end

    tx_state_e        state_r;
    tx_state_e        state_nxt_s;
    logic [CNT_W-1:0] gap_r;
    logic [CNT_W-1:0] gap_nxt_s;
    logic [CNT_W-1:0] pending_s;
    logic [CNT_W-1:0] pend_nxt_s;
    logic             flip_s;
    logic             ovf_stb_s;
    logic             out_r;
    logic             ovf_r;
    logic             busy_r;

    // Flip only from IDLE with something queued, so pending never underflows.
    assign flip_s = (state_r == IDLE) && (pending_s != {CNT_W{1'b0}});

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_pend_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (evt_in),
        .dec     (flip_s),
        .cnt     (pending_s),
        .cnt_nxt (pend_nxt_s),
        .ovf_stb (ovf_stb_s)
    );

    // Spacing FSM: a flip loads GAP-1 and HOLD counts it down to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            IDLE: begin
                if (flip_s) begin
                    gap_nxt_s   = CNT_W'(GAP - 1);
                    state_nxt_s = (GAP > 1) ? HOLD : IDLE;
                end else begin
                    gap_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = IDLE;
                end
            end
            HOLD: begin
                if (gap_r > CNT_W'(1)) begin
                    gap_nxt_s   = gap_r - CNT_W'(1);
                    state_nxt_s = HOLD;
                end else begin
                    gap_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                gap_nxt_s   = {CNT_W{1'b0}};
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, link level, sticky overflow and busy registers; a new overflow beats ovf_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            gap_r   <= {CNT_W{1'b0}};
            out_r   <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            gap_r   <= gap_nxt_s;
            out_r   <= flip_s ? ~out_r : out_r;
            if (ovf_stb_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            busy_r  <= (pend_nxt_s != {CNT_W{1'b0}}) || (gap_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign out     = out_r;
    assign busy    = busy_r;
    assign pending = pending_s;
    assign ovf     = ovf_r;

endmodule
